// File: rtl/lut_reverse_search_if.sv
// -----------------------------------------------------------------------------
// lut_reverse_search_if
//   Request/response bundle for the reverse table search block.
//
//   Signals
//     init_done    table fully built after reset
//     req_valid    query offered by the requester
//     req_ready    block can accept a query this cycle
//     req_value    value to look up (captured when req_valid && req_ready)
//     resp_valid   result available
//     resp_ready   requester consumes the result
//     resp_hit     1 = some table entry equals the query
//     resp_index   lowest matching index (0 on a miss)
//
//   Modports
//     master  requester side (drives req_valid/req_value/resp_ready)
//     slave   search block side (drives everything else)
// -----------------------------------------------------------------------------
interface lut_reverse_search_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              init_done;
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_value;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_hit;
    logic [ADDR_W-1:0] resp_index;

    modport master (
        input  init_done,
        input  req_ready,
        input  resp_valid,
        input  resp_hit,
        input  resp_index,
        output req_valid,
        output req_value,
        output resp_ready
    );

    modport slave (
        output init_done,
        output req_ready,
        output resp_valid,
        output resp_hit,
        output resp_index,
        input  req_valid,
        input  req_value,
        input  resp_ready
    );
endinterface

// File: rtl/lut_reverse_search.sv
// -----------------------------------------------------------------------------
// lut_reverse_search
//   Inverse of the index->value lookup table. The table holds
//   entry[i] = 2*(i+2) (truncated to DATA_W). After reset the block writes its
//   own copy of the table one entry per cycle, then serves one query at a time
//   by scanning the table from index 0 upward and reporting the lowest index
//   whose entry equals the query.
//
//   Ports
//     clk   in   clock, every register updates on the rising edge
//     rst   in   synchronous reset, active-high
//     bus   slave modport of lut_reverse_search_if
//             init_done  out  table built, stays high until the next rst
//             req_*      query handshake (req_value captured at acceptance)
//             resp_*     result handshake (hit flag + index held until taken)
//
//   Timing
//     INIT lasts DEPTH edges after rst falls.
//     A hit at index i raises resp_valid after edge (accept + i + 1);
//     a miss raises it after edge (accept + DEPTH).
//     req_ready / resp_valid / init_done are decoded from the state register
//     only, so no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module lut_reverse_search #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 2 ** ADDR_W,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    lut_reverse_search_if.slave   bus
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_SEARCH = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [ADDR_W-1:0] init_idx_q;
    logic [ADDR_W-1:0] init_idx_d;
    logic [ADDR_W-1:0] scan_idx_q;
    logic [ADDR_W-1:0] scan_idx_d;
    logic [DATA_W-1:0] query_q;
    logic [DATA_W-1:0] query_d;
    logic              resp_hit_q;
    logic              resp_hit_d;
    logic [ADDR_W-1:0] resp_index_q;
    logic [ADDR_W-1:0] resp_index_d;

    // -------------------------------------------------------------------------
    // Table contents source: one constant per entry. The INIT sweep copies
    // these into the table memory, so the scan always reads the memory rather
    // than the constants.
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] entry_const [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry_const
            assign entry_const[gi] = DATA_W'(2 * (gi + 2));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Table memory. The read is combinational on scan_idx_q so every SEARCH
    // edge can compare the addressed entry directly; a registered read would
    // add a cycle to every hit/miss latency. At 16 x 8 this maps to
    // distributed RAM rather than a block RAM.
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] table_mem [DEPTH];
    logic [DATA_W-1:0] init_val;
    logic [DATA_W-1:0] scan_val;

    assign init_val = entry_const[init_idx_q];
    assign scan_val = table_mem[scan_idx_q];

    // Contents are don't-care after reset until rewritten, so no reset here.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            table_mem[init_idx_q] <= init_val;
        end
    end

    // -------------------------------------------------------------------------
    // Shared decodes
    // -------------------------------------------------------------------------
    logic last_init;
    logic last_scan;
    logic scan_match;

    assign last_init  = (init_idx_q == ADDR_W'(DEPTH - 1));
    assign last_scan  = (scan_idx_q == ADDR_W'(DEPTH - 1));
    assign scan_match = (scan_val == query_q);

    // -------------------------------------------------------------------------
    // FSM process 1: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 2: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: begin
                if (last_init) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_d = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (scan_match || last_scan) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                // Returning to IDLE (not accepting directly) keeps the
                // response handshake and the next acceptance on separate
                // edges.
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM process 3: outputs, decoded purely from the state register
    // -------------------------------------------------------------------------
    always_comb begin
        bus.init_done  = (state_q != ST_INIT);
        bus.req_ready  = (state_q == ST_IDLE);
        bus.resp_valid = (state_q == ST_RESP);
        bus.resp_hit   = resp_hit_q;
        bus.resp_index = resp_index_q;
    end

    // -------------------------------------------------------------------------
    // Datapath next-state: init pointer, captured query, scan pointer, result
    // -------------------------------------------------------------------------
    always_comb begin
        init_idx_d   = init_idx_q;
        scan_idx_d   = scan_idx_q;
        query_d      = query_q;
        resp_hit_d   = resp_hit_q;
        resp_index_d = resp_index_q;
        case (state_q)
            ST_INIT: begin
                // Wraps back to 0 after the last entry; unused afterwards.
                init_idx_d = init_idx_q + ADDR_W'(1);
            end
            ST_IDLE: begin
                if (bus.req_valid) begin
                    query_d    = bus.req_value;
                    scan_idx_d = '0;
                end
            end
            ST_SEARCH: begin
                // Scanning upward and stopping at the first equal entry makes
                // the lowest index win when entries repeat.
                if (scan_match) begin
                    resp_hit_d   = 1'b1;
                    resp_index_d = scan_idx_q;
                end else if (last_scan) begin
                    resp_hit_d   = 1'b0;
                    resp_index_d = '0;
                end else begin
                    scan_idx_d = scan_idx_q + ADDR_W'(1);
                end
            end
            default: begin
                // RESP holds the result stable until the handshake.
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            init_idx_q   <= '0;
            scan_idx_q   <= '0;
            query_q      <= '0;
            resp_hit_q   <= 1'b0;
            resp_index_q <= '0;
        end else begin
            init_idx_q   <= init_idx_d;
            scan_idx_q   <= scan_idx_d;
            query_q      <= query_d;
            resp_hit_q   <= resp_hit_d;
            resp_index_q <= resp_index_d;
        end
    end

endmodule

// File: tb/tb_lut_reverse_search.sv
// -----------------------------------------------------------------------------
// tb_lut_reverse_search
//   Directed and randomized checks of lut_reverse_search. A transaction-level
//   model (table rule v even && 4<=v<=34 -> v/2-2, plus the documented
//   latencies) predicts every output each cycle; directed queries also carry
//   hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_lut_reverse_search;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    lut_reverse_search_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc ();

    lut_reverse_search #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model: counts edges rather than tracking FSM states.
    // -------------------------------------------------------------------------
    int m_init_left = DEPTH;   // edges until table is built
    bit m_busy      = 1'b0;    // query accepted, result not yet presented
    int m_cnt       = 0;       // edges left until result is presented
    bit m_out       = 1'b0;    // result presented, waiting for resp_ready
    bit m_hit       = 1'b0;
    int m_idx       = 0;
    int m_val       = 0;
    int acc_count   = 0;       // model acceptances
    bit cmp_en      = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_init_left = DEPTH;
                m_busy      = 1'b0;
                m_out       = 1'b0;
                m_hit       = 1'b0;
                m_idx       = 0;
            end else if (m_init_left > 0) begin
                m_init_left--;
            end else if (m_out) begin
                if (ifc.resp_ready) m_out = 1'b0;
            end else if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 1'b0;
                    m_out  = 1'b1;
                end
            end else if (ifc.req_valid) begin
                m_val = int'(ifc.req_value);
                if ((m_val % 2 == 0) && m_val >= 4 && m_val <= 34) begin
                    m_hit = 1'b1;
                    m_idx = m_val / 2 - 2;
                    m_cnt = m_idx + 1;
                end else begin
                    m_hit = 1'b0;
                    m_idx = 0;
                    m_cnt = DEPTH;
                end
                m_busy = 1'b1;
                acc_count++;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("init_done", int'(ifc.init_done), int'(m_init_left == 0));
                check("req_ready", int'(ifc.req_ready),
                      int'(m_init_left == 0 && !m_busy && !m_out));
                check("resp_valid", int'(ifc.resp_valid), int'(m_out));
                if (m_out) begin
                    check($sformatf("resp_hit q=%0d", m_val), int'(ifc.resp_hit), int'(m_hit));
                    check($sformatf("resp_index q=%0d", m_val), int'(ifc.resp_index), m_idx);
                end
            end
        end
    end

    // Handshakes seen on the DUT pins (inputs settle at negedge, sampled +1).
    int dut_acc  = 0;
    int dut_resp = 0;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst && ifc.req_valid && ifc.req_ready) dut_acc++;
            if (!rst && ifc.resp_valid && ifc.resp_ready) dut_resp++;
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers (all called at a negedge)
    // -------------------------------------------------------------------------
    task automatic do_reset(input int cycles);
        int k = 0;
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        check("rst init_done",  int'(ifc.init_done),  0);
        check("rst req_ready",  int'(ifc.req_ready),  0);
        check("rst resp_valid", int'(ifc.resp_valid), 0);
        check("rst resp_hit",   int'(ifc.resp_hit),   0);
        check("rst resp_index", int'(ifc.resp_index), 0);
        rst = 1'b0;
        while (!ifc.init_done && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("init_latency", k, 16);
    endtask

    task automatic send(input int v, output bit ok);
        int start = acc_count;
        int t     = 0;
        ifc.req_valid = 1'b1;
        ifc.req_value = 8'(v);
        while (acc_count == start && t < 200) begin
            @(negedge clk);
            t++;
        end
        ifc.req_valid = 1'b0;
        ok = (acc_count != start);
        if (!ok) check($sformatf("accept_timeout q=%0d", v), 0, 1);
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (!ifc.resp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic dquery(input int v, input int e_hit, input int e_idx,
                          input int e_lat, input int hold);
        bit ok;
        int lat;
        send(v, ok);
        if (ok) begin
            wait_resp(lat);
            check($sformatf("latency q=%0d", v), lat, e_lat);
            check($sformatf("hit q=%0d", v), int'(ifc.resp_hit), e_hit);
            check($sformatf("index q=%0d", v), int'(ifc.resp_index), e_idx);
            if (hold > 0) begin
                repeat (hold) @(negedge clk);
                check($sformatf("held valid q=%0d", v), int'(ifc.resp_valid), 1);
                check($sformatf("held hit q=%0d", v), int'(ifc.resp_hit), e_hit);
                check($sformatf("held index q=%0d", v), int'(ifc.resp_index), e_idx);
                check($sformatf("held req_ready q=%0d", v), int'(ifc.req_ready), 0);
            end
            ifc.resp_ready = 1'b1;
            @(negedge clk);
            ifc.resp_ready = 1'b0;
            check($sformatf("req_ready after q=%0d", v), int'(ifc.req_ready), 1);
            check($sformatf("valid drop q=%0d", v), int'(ifc.resp_valid), 0);
        end
    endtask

    // -------------------------------------------------------------------------
    // Main sequence
    // -------------------------------------------------------------------------
    initial begin
        bit ok;
        int resp_before;
        int acc_base;
        int resp_base;
        bit done_req;

        ifc.req_valid  = 1'b0;
        ifc.req_value  = '0;
        ifc.resp_ready = 1'b0;

        @(negedge clk);
        cmp_en = 1'b1;

        // Reset release and table build
        do_reset(2);

        // Hits at both ends of the table
        dquery(4,  1, 0,  1,  0);
        dquery(34, 1, 15, 16, 0);

        // Misses: odd value and above range
        dquery(5,  0, 0, 16, 0);
        dquery(36, 0, 0, 16, 0);

        // Backpressure on the response
        dquery(20, 1, 8, 9, 10);

        // Reset in the middle of a search drops the query
        resp_before = dut_resp;
        send(30, ok);
        repeat (5) @(negedge clk);
        do_reset(1);
        check("no resp after mid-search rst", dut_resp, resp_before);
        dquery(30, 1, 13, 14, 0);

        // Sweep of every query value with random valid/ready timing
        acc_base  = dut_acc;
        resp_base = dut_resp;
        done_req  = 1'b0;
        fork
            begin
                bit sok;
                for (int v = 0; v < 256; v++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    send(v, sok);
                end
                done_req = 1'b1;
            end
            begin
                while (!done_req || m_busy || m_out) begin
                    ifc.resp_ready = ($urandom_range(0, 1) == 1);
                    @(negedge clk);
                end
                ifc.resp_ready = 1'b0;
            end
        join
        repeat (2) @(negedge clk);
        check("sweep accepted", dut_acc - acc_base, 256);
        check("sweep responses", dut_resp - resp_base, 256);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #1000000;
        n_bad++;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
